serial_add_sub: RTL

Parametrised multi-cycle adder/subtractor for the ALU datapath. Processes a WIDTH-bit operand pair DIGIT bits per clock, using a ripple of full-adder cells with a registered carry between digits. Reports carry, signed overflow, zero and negative flags, and uses valid/ready handshakes on both sides. It replaces wide single-cycle ripple chains where area matters more than latency.

---
 rtl/serial_add_sub_if.sv | 31 +++
 rtl/serial_add_sub.sv | 117 +++++++++++
 2 files changed

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand and result handshake bundle for serial_add_sub.
//   in_valid/in_ready : operand pair offer / accept (A, B, op, c_in)
//   out_valid/out_ready : result offer / take (S, c_out, ovf, zero, neg)
// master = operand producer and result consumer; slave = the adder/subtractor.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             op;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, A, B, op, c_in, out_ready,
    input  in_ready, out_valid, S, c_out, ovf, zero, neg
  );

  modport slave (
    input  in_valid, A, B, op, c_in, out_ready,
    output in_ready, out_valid, S, c_out, ovf, zero, neg
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock
// with a registered carry between digits. Latency WIDTH/DIGIT cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_sub_if.slave (operand handshake in, result + flags out)
// Optional feature: define SERIAL_ADD_SAT_EN to saturate S on signed overflow.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);
  localparam int unsigned D  = WIDTH / DIGIT;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             c_out_q, ovf_q, zero_q, neg_q, out_valid_q;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] s_wrap, s_res;
  logic             last_dig, ovf_now, accept, take;

  assign accept   = bus.in_valid && (state == IDLE);
  assign take     = bus.out_ready && (state == DONE);
  assign last_dig = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last_dig)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One digit of full-adder cells fed by the carry register
  always_comb begin
    a_dig   = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig   = b_q[cnt_q*DIGIT +: DIGIT];
    sum_dig = '0;
    c       = '0;
    c[0]    = carry_q;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      sum_dig[j] = a_dig[j] ^ b_dig[j] ^ c[j];
      c[j+1]     = (a_dig[j] & b_dig[j]) | (c[j] & (a_dig[j] ^ b_dig[j]));
    end
    // Only meaningful on the final digit, where bit DIGIT-1 is the MSB
    ovf_now = c[DIGIT] ^ c[DIGIT-1];
    s_wrap  = s_q;
    s_wrap[cnt_q*DIGIT +: DIGIT] = sum_dig;
    s_res   = s_wrap;
`ifdef SERIAL_ADD_SAT_EN
    if (ovf_now)
      s_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.op ? ~bus.B : bus.B;
      carry_q <= bus.op ? 1'b1 : bus.c_in;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      carry_q <= c[DIGIT];
      cnt_q   <= cnt_q + 1'b1;
      if (last_dig) begin
        s_q         <= s_res;
        c_out_q     <= c[DIGIT];
        ovf_q       <= ovf_now;
        zero_q      <= (s_res == '0);
        neg_q       <= s_res[WIDTH-1];
        out_valid_q <= 1'b1;
      end else begin
        s_q <= s_wrap;
      end
    end else if (take) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule
